// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: owns the VRAM write port and shares it between buffered
// CPU snoop writes, the loader req/ack handshake and a full-RAM clear sweep.
// One write per cycle at most; every RAM-side output is registered.
module vram_write_arbiter #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_wr_valid,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0]      cpu_data,
  input  logic                       ld_req,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       ld_ack,
  input  logic                       clear_start,
  input  logic [DATA_WIDTH-1:0]      clear_value,
  output logic                       clear_busy,
  output logic                       cpu_overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [DATA_WIDTH-1:0]      ram_data,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic                       ram_we
);

  localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W      = FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W      = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned STREAK_W   = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  entry_t                r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_cpu_overflow;

  logic [ADDR_WIDTH-1:0] r_sweep_addr;
  logic [STREAK_W-1:0]   r_streak;

  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ld_ack;
  logic                  r_clear_busy;

  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_ld_elig;
  logic                  w_streak_max;
  logic                  w_sweep_last;
  logic                  w_is_idle;
  logic                  w_gnt_cpu;
  logic                  w_gnt_ld;
  logic                  w_gnt_clr;
  logic                  w_push;
  logic                  w_pop;
  entry_t                w_head;

  assign w_fifo_empty = (r_level == '0);
  assign w_fifo_full  = (r_level == LVL_W'(FIFO_DEPTH));
  // The ack cycle never re-grants the loader, so one request cannot write twice.
  assign w_ld_elig    = ld_req & ~r_ld_ack;
  assign w_streak_max = (r_streak == STREAK_W'(STARVE_LIMIT));
  assign w_sweep_last = (r_sweep_addr == {ADDR_WIDTH{1'b1}});
  assign w_is_idle    = (r_state == ST_IDLE);
  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_pop        = w_gnt_cpu;
  // A full FIFO still accepts a write when the same cycle pops an entry.
  assign w_push       = cpu_wr_valid & (~w_fifo_full | w_pop);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear_start launches a sweep, the all-ones sweep grant ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clear_start)                 w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_gnt_clr && w_sweep_last)   w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant decode: CPU first, loader when starved or FIFO empty (IDLE only), then sweep.
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_ld  = 1'b0;
    w_gnt_clr = 1'b0;
    if (!w_fifo_empty) begin
      if (w_ld_elig && w_is_idle && w_streak_max) w_gnt_ld  = 1'b1;
      else                                        w_gnt_cpu = 1'b1;
    end else if (w_ld_elig && w_is_idle) begin
      w_gnt_ld = 1'b1;
    end else if (r_state == ST_CLEAR) begin
      w_gnt_clr = 1'b1;
    end
  end

  // CPU FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {cpu_addr, cpu_data};
  end

  // CPU FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_cpu_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (cpu_wr_valid && !w_push) r_cpu_overflow <= 1'b1;
    end
  end

  // Sweep address and loader starvation streak.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sweep_addr <= '0;
      r_streak     <= '0;
    end else begin
      if (w_is_idle && clear_start) r_sweep_addr <= '0;
      else if (w_gnt_clr)           r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);

      if (!ld_req || w_gnt_ld) begin
        r_streak <= '0;
      end else if (w_gnt_cpu && w_ld_elig && w_is_idle && !w_streak_max) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  // Registered RAM port, loader ack and busy flag; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ld_ack     <= 1'b0;
      r_clear_busy <= 1'b0;
    end else begin
      r_ram_we     <= w_gnt_cpu | w_gnt_ld | w_gnt_clr;
      r_ld_ack     <= w_gnt_ld;
      r_clear_busy <= (w_state_nxt == ST_CLEAR);
      if (w_gnt_cpu) begin
        r_ram_addr <= w_head.addr;
        r_ram_data <= w_head.data;
      end else if (w_gnt_ld) begin
        r_ram_addr <= ld_addr;
        r_ram_data <= ld_data;
      end else if (w_gnt_clr) begin
        r_ram_addr <= r_sweep_addr;
        r_ram_data <= clear_value;
      end
    end
  end

  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_data     = r_ram_data;
  assign ld_ack       = r_ld_ack;
  assign clear_busy   = r_clear_busy;
  assign cpu_overflow = r_cpu_overflow;
  assign fifo_level   = r_level;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_vram_write_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned FL2 = 2;
  localparam int unsigned SL  = 4;
  localparam int unsigned DEPTH = 1 << FL2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_wr_valid = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ack;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_value = '0;
  logic          clear_busy;
  logic          cpu_overflow;
  logic [FL2:0]  fifo_level;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  always #5 clk = ~clk;

  vram_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(FL2), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wr_valid(cpu_wr_valid), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .cpu_overflow(cpu_overflow), .fifo_level(fifo_level),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending CPU writes in a queue, sweep position as an integer.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          mq[$];
  bit            m_clear = 1'b0;
  int            m_sweep = 0;
  int            m_streak = 0;
  logic          e_we = 1'b0;
  logic          e_ack = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_ovf = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  initial forever begin : model
    bit elig;
    int who;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_clear = 1'b0; m_sweep = 0; m_streak = 0;
      e_we = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
      e_addr = '0; e_data = '0;
    end else begin
      elig = ld_req && !e_ack;
      // who: 0 none, 1 cpu, 2 loader, 3 sweep
      if (mq.size() > 0)          who = (elig && !m_clear && m_streak == int'(SL)) ? 2 : 1;
      else if (elig && !m_clear)  who = 2;
      else if (m_clear)           who = 3;
      else                        who = 0;

      if (!ld_req || who == 2)                      m_streak = 0;
      else if (who == 1 && elig && !m_clear)        m_streak = (m_streak < int'(SL)) ? m_streak + 1 : m_streak;

      e_we  = (who != 0);
      e_ack = (who == 2);
      if (who == 1) begin
        e_addr = mq[0].a; e_data = mq[0].d;
        void'(mq.pop_front());
      end else if (who == 2) begin
        e_addr = ld_addr; e_data = ld_data;
      end else if (who == 3) begin
        e_addr = AW'(m_sweep); e_data = clear_value;
      end

      if (cpu_wr_valid) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(ent_t'({cpu_addr, cpu_data}));
        else                         e_ovf = 1'b1;
      end

      if (!m_clear && clear_start) begin
        m_clear = 1'b1; m_sweep = 0;
      end else if (who == 3) begin
        if (m_sweep == (1 << AW) - 1) m_clear = 1'b0;
        else                          m_sweep = m_sweep + 1;
      end
      e_busy = m_clear;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin : compare
    @(negedge clk);
    if (cmp_en) begin
      chk("ram_we",       32'(ram_we),       32'(e_we));
      chk("ld_ack",       32'(ld_ack),       32'(e_ack));
      chk("clear_busy",   32'(clear_busy),   32'(e_busy));
      chk("cpu_overflow", 32'(cpu_overflow), 32'(e_ovf));
      chk("fifo_level",   32'(fifo_level),   mq.size());
      if (e_we) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_data", 32'(ram_data), 32'(e_data));
      end else begin
        chk("ram_addr_hold", 32'(ram_addr), 32'(e_addr));
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic run_sweep(input int inject_at, input bit hold_ld,
                           output int busy_cycles, output int sweep_wr, output int ack_busy);
    bit done;
    bit seen_busy;
    busy_cycles = 0; sweep_wr = 0; ack_busy = 0; done = 1'b0; seen_busy = 1'b0;
    @(negedge clk);
    clear_start = 1'b1; clear_value = 8'h20;
    ld_addr = 8'h4A; ld_data = 8'h77;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (ram_we && !ld_ack && ram_data == 8'h20) sweep_wr++;
      if (clear_busy) begin
        seen_busy = 1'b1;
        busy_cycles++;
        if (ld_ack) ack_busy++;
      end else if (seen_busy) begin
        chk("sweep_end_we",   32'(ram_we),   1);
        chk("sweep_end_addr", 32'(ram_addr), 'hFF);
        chk("sweep_end_data", 32'(ram_data), 'h20);
        done = 1'b1;
      end
      if (i == 0) ld_req = hold_ld;
      clear_start  = (i == 50);
      cpu_wr_valid = (i == inject_at);
      cpu_addr = 8'h05; cpu_data = 8'h99;
    end
    chk("sweep_finished", 32'(done), 1);
    clear_start = 1'b0; cpu_wr_valid = 1'b0;
  endtask

  initial begin : stim
    int nc, nl, busy, sw, aib;
    bit found;

    // Reset
    idle(2);
    cmp_en = 1'b1;
    chk("rst_ram_we",     32'(ram_we),     0);
    chk("rst_ram_addr",   32'(ram_addr),   0);
    chk("rst_ld_ack",     32'(ld_ack),     0);
    chk("rst_clear_busy", 32'(clear_busy), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    idle(2);

    // Three back-to-back CPU writes: 2-cycle latency, level peaks at 1
    cpu_wr_valid = 1'b1; cpu_addr = 8'h10; cpu_data = 8'hA0;
    @(negedge clk);
    chk("cpu3_lvl_a", 32'(fifo_level), 1);
    chk("cpu3_we_a",  32'(ram_we),     0);
    cpu_addr = 8'h11; cpu_data = 8'hA1;
    @(negedge clk);
    chk("cpu3_we0",   32'(ram_we),   1);
    chk("cpu3_addr0", 32'(ram_addr), 'h10);
    chk("cpu3_data0", 32'(ram_data), 'hA0);
    chk("cpu3_lvl_b", 32'(fifo_level), 1);
    cpu_addr = 8'h12; cpu_data = 8'hA2;
    @(negedge clk);
    chk("cpu3_addr1", 32'(ram_addr), 'h11);
    chk("cpu3_data1", 32'(ram_data), 'hA1);
    chk("cpu3_lvl_c", 32'(fifo_level), 1);
    cpu_wr_valid = 1'b0;
    @(negedge clk);
    chk("cpu3_addr2", 32'(ram_addr), 'h12);
    chk("cpu3_data2", 32'(ram_data), 'hA2);
    chk("cpu3_lvl_d", 32'(fifo_level), 0);
    @(negedge clk);
    chk("cpu3_we_end", 32'(ram_we), 0);
    idle(2);

    // Loader alone: ack one cycle after req, next ack two cycles later
    ld_req = 1'b1; ld_addr = 8'h40; ld_data = 8'h55;
    @(negedge clk);
    chk("ld_ack0",  32'(ld_ack),   1);
    chk("ld_we0",   32'(ram_we),   1);
    chk("ld_addr0", 32'(ram_addr), 'h40);
    chk("ld_data0", 32'(ram_data), 'h55);
    @(negedge clk);
    chk("ld_gap_ack", 32'(ld_ack), 0);
    chk("ld_gap_we",  32'(ram_we), 0);
    @(negedge clk);
    chk("ld_ack1", 32'(ld_ack), 1);
    ld_req = 1'b0;
    @(negedge clk);
    chk("ld_ack_off", 32'(ld_ack), 0);
    idle(3);

    // Starvation guard: 10 CPU writes with loader waiting; loader every 6th slot
    nc = 0; nl = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("starve_ack_slot", 32'(ld_ack), (i == 1 || i == 7 || i == 13) ? 1 : 0);
      if (ram_we && !ld_ack) nc++;
      if (ram_we && ld_ack)  nl++;
      cpu_wr_valid = (i < 10);
      cpu_addr = AW'(32'h80 + i); cpu_data = DW'(i);
      ld_req = (i < 13); ld_addr = 8'h41; ld_data = 8'h66;
    end
    chk("starve_cpu_writes", nc, 10);
    chk("starve_ld_writes",  nl, 3);
    chk("starve_no_ovf", 32'(cpu_overflow), 0);
    idle(3);

    // Overflow: continuous CPU stream plus loader wins fill the FIFO; one write drops
    nc = 0; nl = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      chk("ovf_ack_slot", 32'(ld_ack), (i % 6 == 1 && i <= 31) ? 1 : 0);
      chk("ovf_flag",     32'(cpu_overflow), (i >= 25) ? 1 : 0);
      if (ram_we && !ld_ack) nc++;
      if (ram_we && ld_ack)  nl++;
      cpu_wr_valid = (i < 26);
      cpu_addr = AW'(32'hC0 + i); cpu_data = DW'(i + 100);
      ld_req = (i < 31); ld_addr = 8'h42; ld_data = 8'h67;
    end
    chk("ovf_cpu_writes", nc, 25);
    chk("ovf_ld_writes",  nl, 6);
    idle(3);

    // Uncontended sweep (a repeated clear_start mid-sweep is ignored)
    run_sweep(-1, 1'b0, busy, sw, aib);
    chk("sweep1_busy_cycles", busy, 256);
    chk("sweep1_writes",      sw,   256);
    idle(3);

    // Sweep with one CPU write injected and the loader held off until the end
    run_sweep(100, 1'b1, busy, sw, aib);
    chk("sweep2_busy_cycles", busy, 257);
    chk("sweep2_writes",      sw,   256);
    chk("sweep2_no_ack_busy", aib,  0);
    @(negedge clk);
    chk("sweep2_ld_ack",  32'(ld_ack),   1);
    chk("sweep2_ld_addr", 32'(ram_addr), 'h4A);
    ld_req = 1'b0;
    idle(3);

    // Reset in the middle of a sweep with a CPU write pending
    chk("ovf_sticky", 32'(cpu_overflow), 1);
    @(negedge clk);
    clear_start = 1'b1; clear_value = 8'h3C;
    @(negedge clk);
    clear_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 8'h7F) found = 1'b1;
    end
    chk("rst_sweep_reached", 32'(found), 1);
    cpu_wr_valid = 1'b1; cpu_addr = 8'h33; cpu_data = 8'hEE;
    @(negedge clk);
    chk("rst_pre_lvl", 32'(fifo_level), 1);
    cpu_wr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_ram_we",   32'(ram_we),       0);
    chk("rst2_ram_addr", 32'(ram_addr),     0);
    chk("rst2_ram_data", 32'(ram_data),     0);
    chk("rst2_busy",     32'(clear_busy),   0);
    chk("rst2_lvl",      32'(fifo_level),   0);
    chk("rst2_ovf",      32'(cpu_overflow), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst2_quiet_we", 32'(ram_we), 0);
    end
    ld_req = 1'b1; ld_addr = 8'h4B; ld_data = 8'h12;
    @(negedge clk);
    chk("rst2_ld_ack",  32'(ld_ack),   1);
    chk("rst2_ld_addr", 32'(ram_addr), 'h4B);
    ld_req = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
